// File: rtl/booth_accumulator.sv
// Streaming saturating accumulator behind the Booth multiplier.
// Sums up to LEN signed products per group and emits the total.
module booth_accumulator #(
  parameter int PW  = 8,
  parameter int AW  = 16,
  parameter int LEN = 4,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic signed [PW-1:0] p_data,
  input  logic                 p_last,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic signed [AW-1:0] acc_data,
  output logic                 acc_sat,
  output logic        [CW-1:0] acc_count
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [CW-1:0] LenC = CW'(LEN);
  localparam logic [AW-1:0] MaxC = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MinC = {1'b1, {(AW-1){1'b0}}};

  state_t          r_state, w_state;
  logic [AW-1:0]   r_sum, w_sum;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_sat, w_sat;
  logic [AW-1:0]   r_odata, w_odata;
  logic            r_osat, w_osat;
  logic [CW-1:0]   r_ocnt, w_ocnt;

  logic [AW:0]     w_ext;
  logic [AW:0]     w_add;
  logic [AW-1:0]   w_clamp;
  logic            w_ovf;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_accept;
  logic            w_term;

  assign w_ext = {{(AW+1-PW){p_data[PW-1]}}, p_data};
  assign w_add = w_ext + {r_sum[AW-1], r_sum};

  // Top two bits disagree only when the AW-bit range was left.
  assign w_ovf   = w_add[AW] ^ w_add[AW-1];
  assign w_clamp = !w_ovf ? w_add[AW-1:0] :
                   (w_add[AW] ? MinC : MaxC);

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_accept  = p_valid && (r_state == FILL);
  assign w_term    = p_last || (w_cnt_inc == LenC);

  always_comb begin
    w_state = r_state;
    w_sum   = r_sum;
    w_cnt   = r_cnt;
    w_sat   = r_sat;
    w_odata = r_odata;
    w_osat  = r_osat;
    w_ocnt  = r_ocnt;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          w_sum = w_clamp;
          w_cnt = w_cnt_inc;
          w_sat = r_sat | w_ovf;
          if (w_term) begin
            w_odata = w_clamp;
            w_osat  = r_sat | w_ovf;
            w_ocnt  = w_cnt_inc;
            w_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          w_sum   = '0;
          w_cnt   = '0;
          w_sat   = 1'b0;
          w_state = FILL;
        end
      end
      default: w_state = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_odata <= '0;
      r_osat  <= 1'b0;
      r_ocnt  <= '0;
    end else begin
      r_state <= w_state;
      r_sum   <= w_sum;
      r_cnt   <= w_cnt;
      r_sat   <= w_sat;
      r_odata <= w_odata;
      r_osat  <= w_osat;
      r_ocnt  <= w_ocnt;
    end
  end

  assign p_ready   = (r_state == FILL);
  assign acc_valid = (r_state == HOLD);
  assign acc_data  = r_odata;
  assign acc_sat   = r_osat;
  assign acc_count = r_ocnt;

endmodule

// File: tb/tb_booth_accumulator.sv
// Directed bench for booth_accumulator (AW=16 and AW=9 instances
// fed from the same product stream).
module tb_booth_accumulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              p_valid;
  logic signed [7:0] p_data;
  logic              p_last;
  logic              acc_ready;

  logic              p_ready_a, acc_valid_a, acc_sat_a;
  logic       [15:0] acc_data_a;
  logic        [2:0] acc_count_a;
  logic              p_ready_b, acc_valid_b, acc_sat_b;
  logic        [8:0] acc_data_b;
  logic        [2:0] acc_count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_accumulator #(.PW(8), .AW(16), .LEN(4)) dut_a (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready_a),
    .p_data(p_data), .p_last(p_last),
    .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .acc_data(acc_data_a), .acc_sat(acc_sat_a),
    .acc_count(acc_count_a)
  );

  booth_accumulator #(.PW(8), .AW(9), .LEN(4)) dut_b (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready_b),
    .p_data(p_data), .p_last(p_last),
    .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .acc_data(acc_data_b), .acc_sat(acc_sat_b),
    .acc_count(acc_count_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is taken.
  task automatic send(input int d, input bit last);
    int n;
    n = 0;
    p_valid = 1'b1;
    p_data  = 8'(d);
    p_last  = last;
    while (!p_ready_a && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<50", n);
    end
    tick();
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic handshake(input string tag);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk({tag, "_vld_clr"}, int'(acc_valid_a), 0);
    chk({tag, "_rdy_set"}, int'(p_ready_a), 1);
  endtask

  initial begin
    rst = 1'b1;
    p_valid = 1'b0;
    p_data = '0;
    p_last = 1'b0;
    acc_ready = 1'b0;
    idle(2);
    chk("rst_p_ready", int'(p_ready_a), 1);
    chk("rst_acc_valid", int'(acc_valid_a), 0);
    chk("rst_acc_data", int'(acc_data_a), 0);
    chk("rst_acc_sat", int'(acc_sat_a), 0);
    chk("rst_acc_count", int'(acc_count_a), 0);
    rst = 1'b0;
    tick();

    // Full group back to back
    send(10, 0);
    send(-3, 0);
    send(25, 0);
    chk("full_not_yet", int'(acc_valid_a), 0);
    send(7, 0);
    chk("full_valid", int'(acc_valid_a), 1);
    chk("full_data", int'($signed(acc_data_a)), 39);
    chk("full_count", int'(acc_count_a), 4);
    chk("full_sat", int'(acc_sat_a), 0);
    chk("full_p_ready", int'(p_ready_a), 0);
    handshake("full");

    // Early termination, then a held result
    send(5, 0);
    send(-12, 1);
    chk("early_data", int'($signed(acc_data_a)), -7);
    chk("early_count", int'(acc_count_a), 2);
    p_valid = 1'b1;
    p_data  = 8'sd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", int'(acc_valid_a), 1);
      chk("hold_data", int'($signed(acc_data_a)), -7);
      chk("hold_count", int'(acc_count_a), 2);
      chk("hold_p_ready", int'(p_ready_a), 0);
    end
    p_valid = 1'b0;
    handshake("early");

    // Positive saturation on the narrow instance
    send(100, 0);
    send(100, 0);
    send(100, 0);
    send(-50, 0);
    chk("psat_b_data", int'($signed(acc_data_b)), 205);
    chk("psat_b_sat", int'(acc_sat_b), 1);
    chk("psat_a_data", int'($signed(acc_data_a)), 250);
    chk("psat_a_sat", int'(acc_sat_a), 0);
    handshake("psat");

    // Negative saturation
    for (int i = 0; i < 4; i++) send(-128, 0);
    chk("nsat_b_data", int'($signed(acc_data_b)), -256);
    chk("nsat_b_sat", int'(acc_sat_b), 1);
    chk("nsat_a_data", int'($signed(acc_data_a)), -512);
    chk("nsat_a_sat", int'(acc_sat_a), 0);
    handshake("nsat");

    // Gaps inside a group
    idle(2); send(1, 0);
    send(2, 0);
    idle(3); send(3, 0);
    idle(1);
    chk("gap_mid_valid", int'(acc_valid_a), 0);
    send(4, 0);
    chk("gap_data", int'($signed(acc_data_a)), 10);
    chk("gap_count", int'(acc_count_a), 4);
    chk("gap_b_sat", int'(acc_sat_b), 0);
    handshake("gap");
    for (int i = 0; i < 4; i++) send(1, 0);
    chk("next_data", int'($signed(acc_data_a)), 4);
    chk("next_b_data", int'($signed(acc_data_b)), 4);
    chk("next_sat", int'(acc_sat_b), 0);
    handshake("next");

    // Reset mid-group discards the partial sum
    send(50, 0);
    send(60, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", int'(acc_valid_a), 0);
    chk("rstmid_p_ready", int'(p_ready_a), 1);
    chk("rstmid_count", int'(acc_count_a), 0);
    idle(2);
    chk("rstmid_still", int'(acc_valid_a), 0);
    send(3, 1);
    chk("after_rst_data", int'($signed(acc_data_a)), 3);
    chk("after_rst_count", int'(acc_count_a), 1);

    // Reset while holding a result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsthold_valid", int'(acc_valid_a), 0);
    chk("rsthold_p_ready", int'(p_ready_a), 1);

    // Redundant p_last on the LEN-th beat
    send(1, 0);
    send(1, 0);
    send(1, 0);
    send(2, 1);
    chk("lenlast_data", int'($signed(acc_data_a)), 5);
    chk("lenlast_count", int'(acc_count_a), 4);
    handshake("lenlast");

    // acc_ready asserted ahead of the result
    acc_ready = 1'b1;
    send(7, 1);
    chk("early_rdy_valid", int'(acc_valid_a), 1);
    chk("early_rdy_data", int'($signed(acc_data_a)), 7);
    tick();
    chk("early_rdy_clr", int'(acc_valid_a), 0);
    chk("early_rdy_keep", int'($signed(acc_data_a)), 7);
    acc_ready = 1'b0;
    send(-1, 1);
    chk("single_neg", int'($signed(acc_data_a)), -1);
    chk("single_neg_b", int'($signed(acc_data_b)), -1);
    handshake("single");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
